mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: launches an operation; sampled on the rising edge.
REQ-004 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port a, input, 32 bits: rs operand (register-file rd1).
REQ-006 SHALL have port b, input, 32 bits: rt operand (register-file rd2).
REQ-007 SHALL have port mthi, input, 1 bit: HI <= a.
REQ-008 SHALL have port mtlo, input, 1 bit: LO <= a.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port hi, output, 32 bits: HI register.
REQ-012 SHALL have port lo, output, 32 bits: LO register.

Function
REQ-013 SHALL implement a state machine with states IDLE and RUN, plus a 5-bit iteration counter.
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored, and op, a and b SHALL be captured on the accepting edge.
REQ-015 SHALL, for start accepted at edge k, hold busy=1 after edge k through edge k+32, then return to IDLE.
REQ-016 SHALL update hi and lo at edge k+32 and assert done for exactly the one cycle following that edge.
REQ-017 SHALL implement multiply as an iterative 1-bit-per-cycle shift-add over operand magnitudes, producing {hi,lo} = 64-bit product.
REQ-018 SHALL treat operands as two's-complement for MULT and DIV, and as unsigned for MULTU and DIVU.
REQ-019 SHALL implement divide as a restoring, 1-bit-per-cycle divide: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
REQ-020 SHALL apply sign correction of the result in the final iteration with no added latency.
REQ-021 SHALL, on divide by zero (b=0), produce lo=32'hFFFFFFFF and hi=a.
REQ-022 SHALL, for DIV of 32'h80000000 by 32'hFFFFFFFF, produce lo=32'h80000000 and hi=0.
REQ-023 SHALL, in IDLE, write HI and/or LO from a at the next edge when mthi and/or mtlo is asserted; both may be asserted together.
REQ-024 SHALL ignore mthi and mtlo while busy, or when start is accepted on the same edge (start has priority).
REQ-025 SHALL hold hi and lo stable during RUN, with hi and lo retaining their previous values until edge k+32.

Reset
REQ-026 SHALL, on rst_n low, immediately clear hi, lo, busy, done, the counter and the captured operands, and enter IDLE.
REQ-027 SHALL, if reset is asserted mid-operation, abort that operation with no done pulse and no result written.
REQ-028 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL use macro MDU_DIV_EN to compile the divider logic in.
REQ-030 SHALL, with MDU_DIV_EN defined, support ops 10 and 11 as specified above.
REQ-031 SHALL, without MDU_DIV_EN, omit the divider: op 10 or 11 with start SHALL complete in 32 cycles with done pulsed and hi and lo unchanged; multiply behaviour is identical in both builds.

Verification
REQ-032 SHALL verify MULT: a=32'hFFFFFFFD (-3), b=7 -> after 32 cycles hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, one-cycle done.
REQ-033 SHALL verify MULTU: a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-034 SHALL verify DIV: a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU with a=100, b=0 -> lo=32'hFFFFFFFF, hi=100.
REQ-035 SHALL verify that a second start at cycle 5 of a multiply is ignored, that mthi with a=32'h12345678 is ignored while busy, and that the same mthi in IDLE gives hi=32'h12345678.
REQ-036 SHALL verify that rst_n pulsed low at cycle 10 of a divide gives busy=0, hi=lo=0 and no done, and that a new start two cycles later completes normally.

Source files
------------

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers. Each operation takes 32 cycles, one bit per cycle.
// Define MDU_DIV_EN to build in the restoring divider. Without it, DIV/DIVU run their 32 cycles and leave HI/LO unchanged.
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic        state;
    logic [4:0]  count;
    logic        is_div;
    logic        neg_res;
    logic [31:0] mag_b;
    logic [63:0] p;

    logic        signed_op;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_res;
    logic [63:0] step_next;
    logic [31:0] fin_hi;
    logic [31:0] fin_lo;

`ifdef MDU_DIV_EN
    logic        neg_rem;
    logic        div_zero;
    logic [31:0] a_q;
    logic [32:0] div_shift;
    logic        div_fits;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] quo;
    logic [31:0] rem;
`endif

    assign busy      = (state == RUN);
    assign signed_op = ~op[0];
    assign abs_a     = (signed_op && a[31]) ? -a : a;
    assign abs_b     = (signed_op && b[31]) ? -b : b;

    // p holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, p[63:32]} + (p[0] ? {1'b0, mag_b} : 33'd0);
        mul_next  = {mul_sum, p[31:1]};
        mul_res   = neg_res ? -mul_next : mul_next;
        fin_hi    = mul_res[63:32];
        fin_lo    = mul_res[31:0];
        step_next = mul_next;
`ifdef MDU_DIV_EN
        div_shift = {p[63:32], p[31]};
        div_fits  = (div_shift >= {1'b0, mag_b});
        div_diff  = div_shift[31:0] - mag_b;
        div_next  = div_fits ? {div_diff, p[30:0], 1'b1}
                             : {div_shift[31:0], p[30:0], 1'b0};
        quo       = div_next[31:0];
        rem       = div_next[63:32];
        if (is_div) begin
            step_next = div_next;
            // Sign fix-up is folded into the last iteration's write-back.
            if (div_zero) begin
                fin_lo = 32'hFFFFFFFF;
                fin_hi = a_q;
            end else begin
                fin_lo = neg_res ? -quo : quo;
                fin_hi = neg_rem ? -rem : rem;
            end
        end
`else
        if (is_div) begin
            step_next = p;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= 5'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            mag_b    <= 32'd0;
            p        <= 64'd0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
`ifdef MDU_DIV_EN
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_q      <= 32'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        count   <= 5'd0;
                        is_div  <= op[1];
                        neg_res <= signed_op && (a[31] ^ b[31]);
                        mag_b   <= abs_b;
                        p       <= {32'd0, abs_a};
`ifdef MDU_DIV_EN
                        neg_rem  <= signed_op && a[31];
                        div_zero <= (b == 32'd0);
                        a_q      <= a;
`endif
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                default: begin
                    p     <= step_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= IDLE;
                        done  <= 1'b1;
`ifdef MDU_DIV_EN
                        hi <= fin_hi;
                        lo <= fin_lo;
`else
                        if (!is_div) begin
                            hi <= fin_hi;
                            lo <= fin_lo;
                        end
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed-vector testbench for mdu. Expected values are hand-computed.
// Division expectations follow the MDU_DIV_EN build setting.
module tb_mdu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared;
    int mismatched;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mdu dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .mthi (mthi),
        .mtlo (mtlo),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Launches one operation from a negedge, follows it to completion, checks timing and result.
    task automatic applyStimulus(input string tag, input logic [1:0] op_in, input logic [31:0] a_in,
                                 input logic [31:0] b_in, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input int inject_at, input logic mthi_in);
        logic [31:0] eh;
        logic [31:0] el;
        int done_at;
        int busy_bad;
        int stable_bad;
        eh = exp_hi;
        el = exp_lo;
`ifndef MDU_DIV_EN
        if (op_in[1]) begin
            eh = model_hi;
            el = model_lo;
        end
`endif
        op = op_in; a = a_in; b = b_in; start = 1'b1; mthi = mthi_in;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; a = 32'd0; b = 32'd0; op = 2'b00;
        done_at = 0; busy_bad = 0; stable_bad = 0;
        for (int j = 1; j <= 40 && done_at == 0; j++) begin
            if (j == inject_at) begin
                start = 1'b1; mthi = 1'b1; a = 32'h12345678; b = 32'd3; op = 2'b01;
            end else if (j == inject_at + 1) begin
                start = 1'b0; mthi = 1'b0; a = 32'd0; b = 32'd0; op = 2'b00;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                done_at = j;
            end else begin
                if (!busy) busy_bad++;
                if (hi !== model_hi || lo !== model_lo) stable_bad++;
            end
        end
        start = 1'b0; mthi = 1'b0;
        checkOutput({tag, "_done_cycle"}, 64'(done_at), 64'd32);
        checkOutput({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        checkOutput({tag, "_hold"}, 64'(stable_bad), 64'd0);
        checkOutput({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        checkOutput({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        checkOutput({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
        model_hi = eh;
        model_lo = el;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    task automatic writeHiLo(input string tag, input logic wr_hi, input logic wr_lo, input logic [31:0] value);
        mthi = wr_hi; mtlo = wr_lo; a = value;
        @(posedge clk);
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; a = 32'd0;
        if (wr_hi) model_hi = value;
        if (wr_lo) model_lo = value;
        checkOutput({tag, "_hi"}, {32'd0, hi}, {32'd0, model_hi});
        checkOutput({tag, "_lo"}, {32'd0, lo}, {32'd0, model_lo});
        checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        compared = 0; mismatched = 0;
        model_hi = 32'd0; model_lo = 32'd0;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0; mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_hi", {32'd0, hi}, 64'd0);
        checkOutput("reset_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;

        applyStimulus("mult_neg",      2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1'b0);
        applyStimulus("multu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 1'b0);
        applyStimulus("mult_extreme",  2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 0, 1'b0);
        applyStimulus("mult_negneg",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 1'b0);
        applyStimulus("multu_inject",  2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 5, 1'b0);

        writeHiLo("mthi_idle", 1'b1, 1'b0, 32'h12345678);
        writeHiLo("mtlo_idle", 1'b0, 1'b1, 32'hCAFEF00D);
        writeHiLo("mt_both",   1'b1, 1'b1, 32'h0BADBEEF);

        applyStimulus("start_prio",    2'b01, 32'd2,        32'd3,        32'h00000000, 32'h00000006, 0, 1'b1);
        applyStimulus("div_neg",       2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1'b0);
        applyStimulus("divu_zero",     2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 0, 1'b0);
        applyStimulus("div_ovf",       2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 1'b0);
        applyStimulus("divu_big",      2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 0, 1'b0);
        applyStimulus("div_negdiv",    2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 1'b0);
        applyStimulus("div_zero_sgn",  2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 0, 1'b0);
        applyStimulus("multu_pow",     2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 0, 1'b0);

        // Abort a divide with a reset pulse at cycle 10.
        op = 2'b10; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_hi", {32'd0, hi}, 64'd0);
        checkOutput("abort_lo", {32'd0, lo}, 64'd0);
        checkOutput("abort_done", {63'd0, done}, 64'd0);
        model_hi = 32'd0; model_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("abort_no_done", {63'd0, done}, 64'd0);
            checkOutput("abort_idle", {63'd0, busy}, 64'd0);
        end
        applyStimulus("divu_after",    2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
